// File: rtl/dram_ctrl.sv
// dram_ctrl: single-outstanding-command DRAM controller.
// Programs read/write latency into MR0/MR1 at start-up, then serves one host
// read or write at a time with latency-aligned data capture and drive.
// Optional macro DRAM_CTRL_MR_READBACK_EN adds an MR readback check during
// init that raises cfg_err on a mismatch.
module dram_ctrl #(
    parameter int RL_DEF = 4,
    parameter int WL_DEF = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       init_done,
    output logic       wr_err,
    output logic       rd_err,
    output logic       cfg_err,
    output logic       DRAM_R,
    output logic       DRAM_W,
    output logic [7:0] DRAM_ADDR,
    output logic [7:0] DRAM_DQ_IN,
    output logic [7:0] DRAM_MR_IN,
    output logic       DRAM_MRW,
    output logic       DRAM_MRR,
    output logic       DRAM_DRIV_VALID,
    input  logic [7:0] DRAM_DQ_OUT,
    input  logic       DRAM_DQ_OE,
    input  logic       DRAM_DQ_IE,
    input  logic [7:0] DRAM_MR_OUT
);

    // A latency of zero is not meaningful to the memory, so it becomes one.
    localparam logic [7:0] RL = (RL_DEF == 0) ? 8'd1 : 8'(RL_DEF);
    localparam logic [7:0] WL = (WL_DEF == 0) ? 8'd1 : 8'(WL_DEF);
    // Wait-counter value k means "this is edge E+k", E being the command edge.
    localparam logic [8:0] RD_TIMEOUT = {1'b0, RL} + 9'd4;
    localparam logic [8:0] WR_DRIVE   = {1'b0, WL} - 9'd1;
    localparam logic [8:0] WR_CHECK   = {1'b0, WL} + 9'd1;

    typedef enum logic [2:0] {
        INIT_MR0,
        INIT_MR1,
`ifdef DRAM_CTRL_MR_READBACK_EN
        INIT_RB0,
        INIT_RB1,
`endif
        IDLE,
        RD_WAIT,
        WR_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] waitCnt_q, waitCnt_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rspValid_q, rspValid_d;
    logic [7:0] rspRdata_q, rspRdata_d;
    logic       initDone_q, initDone_d;
    logic       wrErr_q, wrErr_d;
    logic       rdErr_q, rdErr_d;
    logic       dramR_q, dramR_d;
    logic       dramW_q, dramW_d;
    logic [7:0] dramAddr_q, dramAddr_d;
    logic [7:0] dramDqIn_q, dramDqIn_d;
    logic [7:0] dramMrIn_q, dramMrIn_d;
    logic       dramMrw_q, dramMrw_d;
    logic       dramMrr_q, dramMrr_d;
    logic       dramDriv_q, dramDriv_d;
`ifdef DRAM_CTRL_MR_READBACK_EN
    logic       cfgErr_q, cfgErr_d;
`else
    logic       unusedMrOut;
    assign unusedMrOut = ^DRAM_MR_OUT;
`endif

    // Next-state and next-output logic; every memory-side output idles at 0.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        wdata_d    = wdata_q;
        rspValid_d = 1'b0;
        rspRdata_d = 8'd0;
        initDone_d = initDone_q;
        wrErr_d    = wrErr_q;
        rdErr_d    = rdErr_q;
        dramR_d    = 1'b0;
        dramW_d    = 1'b0;
        dramAddr_d = 8'd0;
        dramDqIn_d = 8'd0;
        dramMrIn_d = 8'd0;
        dramMrw_d  = 1'b0;
        dramMrr_d  = 1'b0;
        dramDriv_d = 1'b0;
`ifdef DRAM_CTRL_MR_READBACK_EN
        cfgErr_d   = cfgErr_q;
`endif
        case (state_q)
            INIT_MR0: begin
                dramMrw_d  = 1'b1;
                dramAddr_d = 8'd0;
                dramMrIn_d = RL;
                state_d    = INIT_MR1;
            end
            INIT_MR1: begin
                dramMrw_d  = 1'b1;
                dramAddr_d = 8'd1;
                dramMrIn_d = WL;
`ifdef DRAM_CTRL_MR_READBACK_EN
                state_d    = INIT_RB0;
`else
                state_d    = IDLE;
                initDone_d = 1'b1;
`endif
            end
`ifdef DRAM_CTRL_MR_READBACK_EN
            INIT_RB0: begin
                dramMrr_d  = 1'b1;
                dramAddr_d = 8'd0;
                waitCnt_d  = 9'd0;
                state_d    = INIT_RB1;
            end
            INIT_RB1: begin
                // Step 0 issues the MR1 read; MR_OUT answers two cycles after each MRR.
                if (waitCnt_q == 9'd0) begin
                    dramMrr_d  = 1'b1;
                    dramAddr_d = 8'd1;
                    waitCnt_d  = waitCnt_q + 9'd1;
                end else if (waitCnt_q == 9'd1) begin
                    if (DRAM_MR_OUT != RL) cfgErr_d = 1'b1;
                    waitCnt_d = waitCnt_q + 9'd1;
                end else begin
                    if (DRAM_MR_OUT != WL) cfgErr_d = 1'b1;
                    state_d    = IDLE;
                    initDone_d = 1'b1;
                end
            end
`endif
            IDLE: begin
                if (req_valid) begin
                    dramAddr_d = req_addr;
                    waitCnt_d  = 9'd0;
                    if (req_write) begin
                        dramW_d = 1'b1;
                        wdata_d = req_wdata;
                        state_d = WR_WAIT;
                    end else begin
                        dramR_d = 1'b1;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (DRAM_DQ_OE) begin
                    rspValid_d = 1'b1;
                    rspRdata_d = DRAM_DQ_OUT;
                    state_d    = IDLE;
                end else if (waitCnt_q == RD_TIMEOUT) begin
                    rdErr_d    = 1'b1;
                    rspValid_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 9'd1;
                end
            end
            WR_WAIT: begin
                if (waitCnt_q == WR_DRIVE) begin
                    dramDriv_d = 1'b1;
                    dramDqIn_d = wdata_q;
                end
                if (waitCnt_q == WR_CHECK) begin
                    if (!DRAM_DQ_IE) wrErr_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 9'd1;
                end
            end
            default: state_d = INIT_MR0;
        endcase
    end

    // State and output registers; reset aborts any command and re-runs init.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= INIT_MR0;
            waitCnt_q  <= 9'd0;
            wdata_q    <= 8'd0;
            rspValid_q <= 1'b0;
            rspRdata_q <= 8'd0;
            initDone_q <= 1'b0;
            wrErr_q    <= 1'b0;
            rdErr_q    <= 1'b0;
            dramR_q    <= 1'b0;
            dramW_q    <= 1'b0;
            dramAddr_q <= 8'd0;
            dramDqIn_q <= 8'd0;
            dramMrIn_q <= 8'd0;
            dramMrw_q  <= 1'b0;
            dramMrr_q  <= 1'b0;
            dramDriv_q <= 1'b0;
`ifdef DRAM_CTRL_MR_READBACK_EN
            cfgErr_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            wdata_q    <= wdata_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            initDone_q <= initDone_d;
            wrErr_q    <= wrErr_d;
            rdErr_q    <= rdErr_d;
            dramR_q    <= dramR_d;
            dramW_q    <= dramW_d;
            dramAddr_q <= dramAddr_d;
            dramDqIn_q <= dramDqIn_d;
            dramMrIn_q <= dramMrIn_d;
            dramMrw_q  <= dramMrw_d;
            dramMrr_q  <= dramMrr_d;
            dramDriv_q <= dramDriv_d;
`ifdef DRAM_CTRL_MR_READBACK_EN
            cfgErr_q   <= cfgErr_d;
`endif
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign rsp_valid       = rspValid_q;
    assign rsp_rdata       = rspRdata_q;
    assign init_done       = initDone_q;
    assign wr_err          = wrErr_q;
    assign rd_err          = rdErr_q;
`ifdef DRAM_CTRL_MR_READBACK_EN
    assign cfg_err         = cfgErr_q;
`else
    assign cfg_err         = 1'b0;
`endif
    assign DRAM_R          = dramR_q;
    assign DRAM_W          = dramW_q;
    assign DRAM_ADDR       = dramAddr_q;
    assign DRAM_DQ_IN      = dramDqIn_q;
    assign DRAM_MR_IN      = dramMrIn_q;
    assign DRAM_MRW        = dramMrw_q;
    assign DRAM_MRR        = dramMrr_q;
    assign DRAM_DRIV_VALID = dramDriv_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: scoreboard bench for dram_ctrl. Two instances share one
// behavioural memory model through a select mux: instance A uses default
// latencies (4/2), instance B uses 0/0 which the controller clamps to 1/1.
`timescale 1ns/1ps
module tb_dram_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST_N;
    logic       sel;
    logic       reqValid, reqWrite;
    logic [7:0] reqAddr, reqWdata;

    logic       forceOeLow, forceIeLow, corruptMr1;
    logic [7:0] modDqOut = 8'd0;
    logic       modOe = 1'b0;
    logic       modIe = 1'b0;
    logic [7:0] modMrOut = 8'd0;

    logic       aReady, aRspValid, aInitDone, aWrErr, aRdErr, aCfgErr;
    logic       aR, aW, aMrw, aMrr, aDriv;
    logic [7:0] aRspRdata, aAddr, aDqIn, aMrIn;
    logic       bReady, bRspValid, bInitDone, bWrErr, bRdErr, bCfgErr;
    logic       bR, bW, bMrw, bMrr, bDriv;
    logic [7:0] bRspRdata, bAddr, bDqIn, bMrIn;

    dram_ctrl #(.RL_DEF(4), .WL_DEF(2)) dutA (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(reqValid && !sel), .req_ready(aReady), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(aRspValid), .rsp_rdata(aRspRdata),
        .init_done(aInitDone), .wr_err(aWrErr), .rd_err(aRdErr), .cfg_err(aCfgErr),
        .DRAM_R(aR), .DRAM_W(aW), .DRAM_ADDR(aAddr), .DRAM_DQ_IN(aDqIn),
        .DRAM_MR_IN(aMrIn), .DRAM_MRW(aMrw), .DRAM_MRR(aMrr), .DRAM_DRIV_VALID(aDriv),
        .DRAM_DQ_OUT(modDqOut), .DRAM_DQ_OE(modOe), .DRAM_DQ_IE(modIe), .DRAM_MR_OUT(modMrOut)
    );

    dram_ctrl #(.RL_DEF(0), .WL_DEF(0)) dutB (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(reqValid && sel), .req_ready(bReady), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(bRspValid), .rsp_rdata(bRspRdata),
        .init_done(bInitDone), .wr_err(bWrErr), .rd_err(bRdErr), .cfg_err(bCfgErr),
        .DRAM_R(bR), .DRAM_W(bW), .DRAM_ADDR(bAddr), .DRAM_DQ_IN(bDqIn),
        .DRAM_MR_IN(bMrIn), .DRAM_MRW(bMrw), .DRAM_MRR(bMrr), .DRAM_DRIV_VALID(bDriv),
        .DRAM_DQ_OUT(modDqOut), .DRAM_DQ_OE(modOe), .DRAM_DQ_IE(modIe), .DRAM_MR_OUT(modMrOut)
    );

    logic       mReady, mRspValid, mInitDone, mWrErr, mRdErr, mCfgErr;
    logic       mR, mW, mMrw, mMrr, mDriv;
    logic [7:0] mRspRdata, mAddr, mDqIn, mMrIn;
    assign mReady    = sel ? bReady    : aReady;
    assign mRspValid = sel ? bRspValid : aRspValid;
    assign mRspRdata = sel ? bRspRdata : aRspRdata;
    assign mInitDone = sel ? bInitDone : aInitDone;
    assign mWrErr    = sel ? bWrErr    : aWrErr;
    assign mRdErr    = sel ? bRdErr    : aRdErr;
    assign mCfgErr   = sel ? bCfgErr   : aCfgErr;
    assign mR        = sel ? bR        : aR;
    assign mW        = sel ? bW        : aW;
    assign mMrw      = sel ? bMrw      : aMrw;
    assign mMrr      = sel ? bMrr      : aMrr;
    assign mDriv     = sel ? bDriv     : aDriv;
    assign mAddr     = sel ? bAddr     : aAddr;
    assign mDqIn     = sel ? bDqIn     : aDqIn;
    assign mMrIn     = sel ? bMrIn     : aMrIn;

    int cyc = 0;
    // Count rising edges so expectations can be stated in edge numbers.
    always @(posedge CLK) cyc <= cyc + 1;

    logic [7:0] mem [256];
    logic [7:0] mr [2];
    logic [7:0] wrAddr = 8'd0;
    logic [7:0] rdAddr = 8'd0;
    logic [7:0] rdCnt = 8'd0;
    logic       rdPend = 1'b0;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        mr[0] = 8'd0;
        mr[1] = 8'd0;
    end

    // Memory model: latencies taken from its own mode registers.
    always @(posedge CLK) begin
        modOe <= 1'b0;
        modIe <= (mDriv === 1'b1) && !forceIeLow;
        if (mMrw === 1'b1) mr[mAddr[0]] <= (corruptMr1 && mAddr[0]) ? 8'd3 : mMrIn;
        if (mMrr === 1'b1) modMrOut <= mr[mAddr[0]];
        if (mDriv === 1'b1) mem[wrAddr] <= mDqIn;
        if (mW === 1'b1) wrAddr <= mAddr;
        if (rdPend) begin
            if (rdCnt == 8'd0) begin
                modOe    <= !forceOeLow;
                modDqOut <= forceOeLow ? 8'hEE : mem[rdAddr];
                rdPend   <= 1'b0;
            end else begin
                rdCnt <= rdCnt - 8'd1;
            end
        end
        if (mR === 1'b1) begin
            if (mr[0] <= 8'd1) begin
                modOe    <= !forceOeLow;
                modDqOut <= forceOeLow ? 8'hEE : mem[mAddr];
            end else begin
                rdPend <= 1'b1;
                rdCnt  <= mr[0] - 8'd2;
                rdAddr <= mAddr;
            end
        end
        if (RST_N !== 1'b1) rdPend <= 1'b0;
    end

    int checks = 0;
    int errors = 0;
    int drivSeen = 0;
    int curRL, curWL;
    logic [7:0] expMem [256];
    int rspDataQ[$];
    int rspCycQ[$];
    int wrDataQ[$];
    int wrCycQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard monitor: pop expectations when responses or write drives appear.
    always @(negedge CLK) begin
        if (mRspValid === 1'b1) begin
            if (rspDataQ.size() == 0) checkOutput("rspUnexpected", 1, 0);
            else begin
                checkOutput("rspCycle", cyc, rspCycQ.pop_front());
                checkOutput("rspData", {24'd0, mRspRdata}, rspDataQ.pop_front());
            end
        end
        if (mDriv === 1'b1) begin
            drivSeen++;
            if (wrDataQ.size() == 0) checkOutput("drivUnexpected", 1, 0);
            else begin
                checkOutput("drivCycle", cyc, wrCycQ.pop_front());
                checkOutput("drivData", {24'd0, mDqIn}, wrDataQ.pop_front());
            end
        end else if (RST_N === 1'b1 && mDqIn !== 8'd0) begin
            checkOutput("dqInIdle", {24'd0, mDqIn}, 0);
        end
    end

    task automatic waitReady();
        int i;
        for (i = 0; i < 60 && mReady !== 1'b1; i++) @(negedge CLK);
        if (mReady !== 1'b1) checkOutput("readyTimeout", 0, 1);
    endtask

    task automatic drainWait();
        for (int i = 0; i < 40 && (rspDataQ.size() != 0 || wrDataQ.size() != 0 || mReady !== 1'b1); i++)
            @(negedge CLK);
        if (rspDataQ.size() != 0 || wrDataQ.size() != 0)
            checkOutput("drainTimeout", rspDataQ.size() + wrDataQ.size(), 0);
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        int a;
        waitReady();
        reqValid = 1'b1;
        reqWrite = wr;
        reqAddr  = addr;
        reqWdata = data;
        a = cyc + 1;
        if (wr) begin
            expMem[addr] = data;
            wrDataQ.push_back(data);
            wrCycQ.push_back(a + curWL);
        end else begin
            rspDataQ.push_back(forceOeLow ? 0 : expMem[addr]);
            rspCycQ.push_back(a + 1 + curRL + (forceOeLow ? 4 : 0));
        end
        @(negedge CLK);
        reqValid = 1'b0;
        checkOutput(wr ? "cmdW" : "cmdR", wr ? mW : mR, 1);
        checkOutput("cmdAddr", mAddr, addr);
    endtask

    task automatic resetDut(input logic s, input int n);
        sel = s;
        reqValid = 1'b0;
        RST_N = 1'b0;
        rspDataQ.delete(); rspCycQ.delete(); wrDataQ.delete(); wrCycQ.delete();
        curRL = s ? 1 : 4;
        curWL = s ? 1 : 2;
        repeat (n) @(negedge CLK);
        checkOutput("rstReady", mReady, 0);
        checkOutput("rstInitDone", mInitDone, 0);
        checkOutput("rstMrw", mMrw, 0);
        checkOutput("rstW", mW, 0);
        checkOutput("rstDriv", mDriv, 0);
        checkOutput("rstWrErr", mWrErr, 0);
        checkOutput("rstRdErr", mRdErr, 0);
        checkOutput("rstCfgErr", mCfgErr, 0);
        checkOutput("rstRsp", mRspValid, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("mr0Mrw", mMrw, 1);
        checkOutput("mr0Addr", mAddr, 0);
        checkOutput("mr0Val", mMrIn, curRL);
        checkOutput("mr0InitDone", mInitDone, 0);
        @(negedge CLK);
        checkOutput("mr1Mrw", mMrw, 1);
        checkOutput("mr1Addr", mAddr, 1);
        checkOutput("mr1Val", mMrIn, curWL);
`ifdef DRAM_CTRL_MR_READBACK_EN
        checkOutput("mr1InitDone", mInitDone, 0);
        @(negedge CLK);
        checkOutput("rb0Mrr", mMrr, 1);
        checkOutput("rb0Addr", mAddr, 0);
        checkOutput("rb0Mrw", mMrw, 0);
        @(negedge CLK);
        checkOutput("rb1Mrr", mMrr, 1);
        checkOutput("rb1Addr", mAddr, 1);
        @(negedge CLK);
        checkOutput("rbWaitMrr", mMrr, 0);
        checkOutput("rbWaitInitDone", mInitDone, 0);
        @(negedge CLK);
        checkOutput("initDone", mInitDone, 1);
        checkOutput("cfgErr", mCfgErr, corruptMr1);
`else
        checkOutput("initDone", mInitDone, 1);
`endif
        @(negedge CLK);
        checkOutput("mrwQuiet", mMrw, 0);
        checkOutput("readyIdle", mReady, 1);
    endtask

    initial begin
        RST_N = 1'b0;
        sel = 1'b0;
        reqValid = 1'b0; reqWrite = 1'b0; reqAddr = 8'd0; reqWdata = 8'd0;
        forceOeLow = 1'b0; forceIeLow = 1'b0; corruptMr1 = 1'b0;
        for (int i = 0; i < 256; i++) expMem[i] = 8'd0;

        resetDut(1'b0, 2);

        applyStimulus(1'b1, 8'h10, 8'hA5);
        applyStimulus(1'b0, 8'h10, 8'h00);
        drainWait();
        checkOutput("wrErrClean", mWrErr, 0);
        checkOutput("rdErrClean", mRdErr, 0);

        applyStimulus(1'b1, 8'h20, 8'h3C);
        applyStimulus(1'b1, 8'hFF, 8'h5A);
        applyStimulus(1'b1, 8'h00, 8'hC3);
        applyStimulus(1'b0, 8'h20, 8'h00);
        applyStimulus(1'b0, 8'hFF, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 8'h55, 8'h00);
        drainWait();

        forceOeLow = 1'b1;
        applyStimulus(1'b0, 8'h10, 8'h00);
        drainWait();
        forceOeLow = 1'b0;
        checkOutput("rdErrTimeout", mRdErr, 1);
        applyStimulus(1'b0, 8'h20, 8'h00);
        drainWait();
        checkOutput("rdErrSticky", mRdErr, 1);

        forceIeLow = 1'b1;
        applyStimulus(1'b1, 8'h30, 8'h66);
        drainWait();
        forceIeLow = 1'b0;
        checkOutput("wrErrNoIe", mWrErr, 1);

        begin
            int drivBefore;
            waitReady();
            reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 8'h40; reqWdata = 8'h99;
            @(negedge CLK);
            reqValid = 1'b0;
            checkOutput("abortCmdW", mW, 1);
            drivBefore = drivSeen;
            resetDut(1'b0, 1);
            repeat (4) @(negedge CLK);
            checkOutput("abortNoDriv", drivSeen, drivBefore);
        end

        resetDut(1'b1, 2);
        applyStimulus(1'b1, 8'hFF, 8'h77);
        applyStimulus(1'b0, 8'hFF, 8'h00);
        drainWait();
        checkOutput("minLatWrErr", mWrErr, 0);
        checkOutput("minLatRdErr", mRdErr, 0);

`ifdef DRAM_CTRL_MR_READBACK_EN
        corruptMr1 = 1'b1;
        resetDut(1'b0, 2);
        corruptMr1 = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter RL_DEF, default 4, meaning read latency written to MR0 at init; a value of 0 is clamped to 1.
REQ-002 SHALL have parameter WL_DEF, default 2, meaning write latency written to MR1 at init; a value of 0 is clamped to 1.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have host ports: req_valid in 1, req_ready out 1, req_write in 1, req_addr in 8, req_wdata in 8.
REQ-006 SHALL have response ports: rsp_valid out 1, rsp_rdata out 8.
REQ-007 SHALL have status ports: init_done out 1, wr_err out 1 (sticky), rd_err out 1 (sticky), cfg_err out 1 (sticky).
REQ-008 SHALL have memory-side outputs DRAM_R 1, DRAM_W 1, DRAM_ADDR 8, DRAM_DQ_IN 8, DRAM_MR_IN 8, DRAM_MRW 1, DRAM_MRR 1 and DRAM_DRIV_VALID 1, all registered.
REQ-009 SHALL have memory-side inputs DRAM_DQ_OUT 8, DRAM_DQ_OE 1, DRAM_DQ_IE 1 and DRAM_MR_OUT 8.

Function
REQ-010 SHALL implement FSM states INIT_MR0, INIT_MR1, [INIT_RB0, INIT_RB1], IDLE, RD_WAIT, WR_WAIT.
REQ-011 INIT_MR0 SHALL drive MRW=1, ADDR=0, MR_IN=RL for one cycle, then go to INIT_MR1.
REQ-012 INIT_MR1 SHALL drive MRW=1, ADDR=1, MR_IN=WL for one cycle, then go to INIT_RB0 (macro defined) or IDLE.
REQ-013 init_done SHALL rise on IDLE entry and stay high until reset.
REQ-014 req_ready SHALL be high only in IDLE; a transfer occurs when req_valid and req_ready are both high; only one command is outstanding at a time.
REQ-015 On a read accept, the block SHALL drive R=1 and ADDR=req_addr for exactly one cycle; the memory samples it at edge E; state then goes to RD_WAIT.
REQ-016 RD_WAIT SHALL capture DQ_OUT at the first edge that samples DQ_OE=1 (nominally E+RL), then pulse rsp_valid for one cycle with rsp_rdata=captured data, and return to IDLE.
REQ-017 If DQ_OE is not seen by edge E+RL+4, the block SHALL set rd_err, pulse rsp_valid with rsp_rdata=0, and return to IDLE.
REQ-018 On a write accept, the block SHALL drive W=1 and ADDR=req_addr for one cycle (edge E), latch req_wdata, and go to WR_WAIT.
REQ-019 WR_WAIT SHALL drive DQ_IN=wdata and DRIV_VALID=1 for exactly the cycle sampled at edge E+WL; DQ_IN SHALL be 0 otherwise.
REQ-020 The block SHALL set wr_err if DQ_IE is not high in the cycle after edge E+WL, and SHALL return to IDLE that cycle.
REQ-021 The wait counter SHALL be 9 bits so that RL+4 with RL=255 does not wrap.
REQ-022 All memory-side command outputs SHALL be 0 whenever they are not being actively driven.
REQ-023 req_valid while not in IDLE SHALL be ignored (the host must hold its request).

Reset
REQ-024 With RST_N low at an edge, state SHALL become INIT_MR0, all outputs 0 (req_ready=0, init_done=0), and error flags cleared.
REQ-025 Reset asserted mid-read or mid-write SHALL abort the operation: no rsp_valid, no DRIV_VALID, and init re-runs.

Configuration
REQ-026 Macro DRAM_CTRL_MR_READBACK_EN: when defined, INIT_RB0/INIT_RB1 SHALL drive MRR=1 with ADDR=0 and then ADDR=1, and compare MR_OUT two cycles after each MRR against RL and WL respectively.
REQ-027 On a readback mismatch, cfg_err SHALL be set and init still completes; without the macro there are no RB states and cfg_err is tied to 0.

Verification
REQ-028 Reset, then idle: MRW pulses with (0,4) then (1,2); init_done=1 at cycle 2 (cycle 6 with the macro).
REQ-029 Write addr 0x10 data 0xA5, then read 0x10: DRIV_VALID at E+2, rsp_rdata=0xA5 at E+RL+1, and wr_err=rd_err=0.
REQ-030 Model with DQ_OE forced to 0: a read gives rsp_valid with data 0 after RL+4 cycles and rd_err=1.
REQ-031 RL_DEF=0, WL_DEF=0: MR_IN writes 1,1; a write/read round trip to 0xFF returns the written data.
REQ-032 Macro on, model MR1 corrupted to 3: cfg_err=1 and init_done=1.
REQ-033 Reset pulsed 1 cycle after a write accept: no DRIV_VALID, and the init sequence restarts.
